decoder_scan_ctrl: RTL
======================

DECODER_SCAN_CTRL -- requirements
Module: decoder_scan_ctrl

Interface
REQ-001 Parameter: DWELL_W, default 8, width of the per-channel dwell count.
REQ-002 clk  input  1  single clock; all state advances on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  level sampled each clk; begins a scan when in IDLE.
REQ-005 stop  input  1  level sampled each clk; aborts any scan.
REQ-006 cont  input  1  0 = single pass, 1 = continuous (wrap) scanning; captured at scan start.
REQ-007 chan_mask  input  8  channels to visit (bit i = channel i); captured at scan start.
REQ-008 dwell  input  DWELL_W  cycles each channel stays enabled; captured at scan start; 0 treated as 1.
REQ-009 sel  output  3  channel select driving the 3-to-8 decoder input.
REQ-010 en_n  output  1  active-low enable driving the decoder enable.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 pass_done  output  1  one-cycle pulse at the end of each pass over the mask.

Function
REQ-013 All outputs SHALL be registered; states are IDLE, SEEK, DWELL, GAP.
REQ-014 IDLE: en_n=1, busy=0; sel holds its last value.
REQ-015 IDLE with start=1, stop=0 and chan_mask!=0: capture mask/dwell/cont, pointer=0, go to SEEK.
REQ-016 start with chan_mask==0 SHALL be ignored (stay IDLE, busy stays 0, no pass_done).
REQ-017 SEEK (1 cycle, en_n=1): select the lowest set mask bit with index >= pointer; if found, load sel with it and go to DWELL.
REQ-018 SEEK with no set bit >= pointer (pointer 8 included): pulse pass_done; if cont=1, load sel with the lowest set bit and go to DWELL; if cont=0, go to IDLE.
REQ-019 DWELL: en_n=0 for exactly max(dwell,1) consecutive cycles, then go to GAP.
REQ-020 GAP: exactly 1 cycle with en_n=1 (break-before-make), pointer=sel+1 (4-bit, 7 -> 8), then go to SEEK.
REQ-021 Latency: start sampled at edge k -> SEEK after k, first en_n=0 after edge k+1; channel-to-channel period = D+2 cycles.
REQ-022 stop=1 in any state SHALL force IDLE at the next edge with en_n=1 and busy=0 and no pass_done; stop wins over a simultaneous start.
REQ-023 start while busy SHALL be ignored; input changes during a scan SHALL NOT affect it.
REQ-024 en_n=0 SHALL occur only in DWELL; sel SHALL NOT change while en_n=0.

Reset
REQ-025 rst=1 SHALL asynchronously force IDLE, sel=0, en_n=1, busy=0, pass_done=0, pointer=0, dwell counter=0, captured mask=0.
REQ-026 Reset asserted mid-DWELL SHALL drop the enable (en_n=1) without waiting for a clock edge.

Structure
REQ-027 A shared package SHALL hold the state enum (IDLE, SEEK, DWELL, GAP) and the constant NUM_CH=8.
REQ-028 One sub-module, next_chan_find, SHALL be combinational: inputs mask[7:0] and pointer[3:0]; outputs found, idx[2:0], first_idx[2:0].

Verification
REQ-029 mask=8'b0010_0101, dwell=3, cont=0, start pulse -> sel 0,2,5 each with en_n=0 for 3 cycles, 1-cycle gaps, pass_done pulses once, then IDLE.
REQ-030 mask=8'h80, dwell=0, cont=1 -> sel=7 with en_n=0 for 1 cycle, then GAP and SEEK (pass_done pulse), repeating with period 3 until stop.
REQ-031 mask=8'h00, start=1 -> busy stays 0, en_n stays 1, no pass_done.
REQ-032 mask=8'hFF, dwell=5; stop on the 3rd DWELL cycle of channel 1 -> en_n=1 and busy=0 after the next edge; no pass_done.
REQ-033 start and stop both high in IDLE -> remains IDLE; start during a scan -> scan sequence unchanged.
REQ-034 rst asserted mid-DWELL (sel=3) -> en_n=1, sel=0 immediately without a clock edge; after release, stays IDLE until start.

Source files
------------

// File: rtl/decoder_scan_ctrl_pkg.sv
// Shared types and constants for the 3-to-8 decoder scan controller.
package decoder_scan_ctrl_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;
    localparam int PTR_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEEK  = 2'd1,
        DWELL = 2'd2,
        GAP   = 2'd3
    } state_t;

endpackage

// File: rtl/decoder_scan_ctrl_next_chan_find.sv
// Combinational search for the next enabled channel at or above the scan
// pointer, plus the lowest enabled channel overall for wrap-around.
module next_chan_find
    import decoder_scan_ctrl_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [PTR_W-1:0]  pointer,
    output logic              found,
    output logic [SEL_W-1:0]  idx,
    output logic [SEL_W-1:0]  first_idx
);

    // Walk from the top down so the last hit written is the lowest index.
    always_comb begin
        found     = 1'b0;
        idx       = '0;
        first_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                first_idx = SEL_W'(i);
                if (PTR_W'(i) >= pointer) begin
                    found = 1'b1;
                    idx   = SEL_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scans a 3-to-8 decoder across a channel mask, holding each channel enabled
// for a programmable dwell with a one-cycle break-before-make gap.
module decoder_scan_ctrl
    import decoder_scan_ctrl_pkg::*;
#(
    parameter int DWELL_W = 8
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               cont,
    input  logic [NUM_CH-1:0]  chan_mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [SEL_W-1:0]   sel,
    output logic               en_n,
    output logic               busy,
    output logic               pass_done
);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               en_n_q, en_n_d;
    logic               busy_q, busy_d;
    logic               pass_done_q, pass_done_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0]  mask_q, mask_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               cont_q, cont_d;

    logic               found;
    logic [SEL_W-1:0]   idx;
    logic [SEL_W-1:0]   first_idx;

    next_chan_find u_find (
        .mask      (mask_q),
        .pointer   (ptr_q),
        .found     (found),
        .idx       (idx),
        .first_idx (first_idx)
    );

    // dwell_q already holds max(dwell,1), so the down-counter loads dwell_q-1.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        pass_done_d = 1'b0;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        mask_d      = mask_q;
        dwell_d     = dwell_q;
        cont_d      = cont_q;

        case (state_q)
            IDLE: begin
                if (start && !stop && (chan_mask != '0)) begin
                    mask_d  = chan_mask;
                    dwell_d = (dwell == '0) ? DWELL_W'(1) : dwell;
                    cont_d  = cont;
                    ptr_d   = '0;
                    state_d = SEEK;
                end
            end
            SEEK: begin
                if (found) begin
                    sel_d   = idx;
                    cnt_d   = dwell_q - DWELL_W'(1);
                    state_d = DWELL;
                end else begin
                    pass_done_d = 1'b1;
                    if (cont_q) begin
                        sel_d   = first_idx;
                        cnt_d   = dwell_q - DWELL_W'(1);
                        state_d = DWELL;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DWELL: begin
                if (cnt_q == '0) begin
                    ptr_d   = {1'b0, sel_q} + PTR_W'(1);
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end
            end
            GAP: begin
                state_d = SEEK;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (stop) begin
            state_d     = IDLE;
            pass_done_d = 1'b0;
        end
    end

    assign busy_d = (state_d != IDLE);
    assign en_n_d = (state_d != DWELL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            en_n_q      <= 1'b1;
            busy_q      <= 1'b0;
            pass_done_q <= 1'b0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            mask_q      <= '0;
            dwell_q     <= '0;
            cont_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            en_n_q      <= en_n_d;
            busy_q      <= busy_d;
            pass_done_q <= pass_done_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            dwell_q     <= dwell_d;
            cont_q      <= cont_d;
        end
    end

    assign sel       = sel_q;
    assign en_n      = en_n_q;
    assign busy      = busy_q;
    assign pass_done = pass_done_q;

endmodule
